// File: rtl/dmem_req_queue.sv
// In-order data-memory request queue between commit and the dcache.
// Flush kills queued/in-flight loads; committed stores always complete.
module dmem_req_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        u_req,
  input  logic        u_wr,
  input  logic [31:0] u_addr,
  input  logic [1:0]  u_size,
  input  logic [31:0] u_wdata,
  input  logic [3:0]  u_wstrb,
  output logic        u_addr_ok,
  output logic        u_data_ok,
  output logic [31:0] u_rdata,
  output logic        d_req,
  output logic        d_wr,
  output logic [31:0] d_addr,
  output logic [1:0]  d_size,
  output logic [31:0] d_wdata,
  output logic [3:0]  d_wstrb,
  input  logic        d_addr_ok,
  input  logic        d_data_ok,
  input  logic [31:0] d_rdata,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [OW:0] MAX_CNT  = (OW+1)'(MAX_OUT);

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t             q [DEPTH];
  logic [DEPTH-1:0] q_kill;
  logic [AW:0]      wp, rp, count;

  // in-flight tracking: one kill/wr bit per downstream-accepted request
  logic [2**OW-1:0] f_kill, f_wr;
  logic [OW:0]      fwp, frp, out_cnt;

  req_t head;
  logic full, empty, head_kill, issue, drop, pop, ret, ret_kill;

  assign head      = q[rp[AW-1:0]];
  assign head_kill = q_kill[rp[AW-1:0]];
  assign count     = wp - rp;
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);

  assign u_addr_ok = u_req & ~full & ~flush;
  assign d_req     = ~empty & ~head_kill & (out_cnt < MAX_CNT);
  assign d_wr      = head.wr;
  assign d_addr    = head.addr;
  assign d_size    = head.size;
  assign d_wdata   = head.wdata;
  assign d_wstrb   = head.wstrb;

  assign issue = d_req & d_addr_ok;
  assign drop  = ~empty & head_kill;
  assign pop   = issue | drop;
  assign ret   = d_data_ok & (out_cnt != '0);
  // a load returning in the flush cycle is already stale
  assign ret_kill = f_kill[frp[OW-1:0]] | (flush & ~f_wr[frp[OW-1:0]]);
  assign busy  = ~empty | (out_cnt != '0);

  always_ff @(posedge clk) begin
    if (u_addr_ok) q[wp[AW-1:0]] <= '{wr: u_wr, addr: u_addr, size: u_size,
                                      wdata: u_wdata, wstrb: u_wstrb};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp        <= '0;
      rp        <= '0;
      q_kill    <= '0;
      fwp       <= '0;
      frp       <= '0;
      f_kill    <= '0;
      f_wr      <= '0;
      out_cnt   <= '0;
      u_data_ok <= 1'b0;
      u_rdata   <= '0;
    end else begin
      if (flush)
        for (int i = 0; i < DEPTH; i++)
          if (!q[i].wr) q_kill[i] <= 1'b1;
      if (u_addr_ok) begin
        q_kill[wp[AW-1:0]] <= 1'b0;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;

      if (flush)
        for (int j = 0; j < 2**OW; j++)
          if (!f_wr[j]) f_kill[j] <= 1'b1;
      if (issue) begin
        f_kill[fwp[OW-1:0]] <= flush & ~head.wr;
        f_wr[fwp[OW-1:0]]   <= head.wr;
        fwp <= fwp + 1'b1;
      end
      if (ret) frp <= frp + 1'b1;

      case ({issue, ret})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase

      u_data_ok <= ret & ~ret_kill;
      if (ret & ~ret_kill) u_rdata <= d_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_req_queue.sv
// Bench for dmem_req_queue: vector table for fill/backpressure plus
// hand sequences for flush, simultaneous issue/return and reset.
module tb_dmem_req_queue;
  logic        clk = 1'b0;
  logic        reset, flush, u_req, u_wr;
  logic [31:0] u_addr, u_wdata;
  logic [1:0]  u_size;
  logic [3:0]  u_wstrb;
  logic        u_addr_ok, u_data_ok;
  logic [31:0] u_rdata;
  logic        d_req, d_wr;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb [$];

  dmem_req_queue #(.DEPTH(4), .MAX_OUT(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .u_req(u_req), .u_wr(u_wr), .u_addr(u_addr), .u_size(u_size),
    .u_wdata(u_wdata), .u_wstrb(u_wstrb),
    .u_addr_ok(u_addr_ok), .u_data_ok(u_data_ok), .u_rdata(u_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_size(d_size),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // one dcache response; a kept response is expected upstream next cycle
  task automatic respond(input logic [31:0] rd, input bit kept);
    d_data_ok = 1'b1;
    d_rdata   = rd;
    if (kept) sb.push_back(rd);
    @(posedge clk); #1;
    d_data_ok = 1'b0;
    d_rdata   = '0;
    #1;
    chk("u_data_ok_after_resp", {31'b0, u_data_ok}, {31'b0, kept});
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (u_data_ok === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: u_data_ok=1 rdata=%h, expected no response", u_rdata);
      end else begin
        e = sb.pop_front();
        if (u_rdata !== e) begin
          fails++;
          $display("FAIL resp_rdata: got %h, expected %h", u_rdata, e);
        end
      end
    end
  end

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          dok;
    bit          exp_ok;
    bit          exp_dreq;
    logic [31:0] exp_daddr;
  } vec_t;
  vec_t vt [10];

  initial begin
    vt[0] = '{1, 32'h200, 0, 1, 0, 32'h0};
    vt[1] = '{1, 32'h204, 0, 1, 1, 32'h200};
    vt[2] = '{1, 32'h208, 0, 1, 1, 32'h200};
    vt[3] = '{1, 32'h20C, 0, 1, 1, 32'h200};
    vt[4] = '{1, 32'h210, 0, 0, 1, 32'h200};
    vt[5] = '{1, 32'h210, 1, 0, 1, 32'h200};
    vt[6] = '{1, 32'h210, 1, 1, 1, 32'h204};
    vt[7] = '{0, 32'h0,   1, 0, 1, 32'h208};
    vt[8] = '{0, 32'h0,   1, 0, 1, 32'h20C};
    vt[9] = '{0, 32'h0,   1, 0, 0, 32'h0};

    reset = 0; flush = 0; u_req = 0; u_wr = 0; u_addr = 0; u_size = 0;
    u_wdata = 0; u_wstrb = 0; d_addr_ok = 0; d_data_ok = 0; d_rdata = 0;
    repeat (2) tick;
    #1;
    chk("rst_u_data_ok", {31'b0, u_data_ok}, 32'd0);
    chk("rst_u_rdata", u_rdata, 32'd0);
    chk("rst_d_req", {31'b0, d_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1;
    tick;

    // single store round trip
    u_req = 1; u_wr = 1; u_addr = 32'h100; u_size = 2;
    u_wdata = 32'hDEADBEEF; u_wstrb = 4'hF; d_addr_ok = 1;
    #1;
    chk("st_addr_ok", {31'b0, u_addr_ok}, 32'd1);
    chk("st_no_bypass", {31'b0, d_req}, 32'd0);
    tick;
    u_req = 0;
    #1;
    chk("st_d_req", {31'b0, d_req}, 32'd1);
    chk("st_d_wr", {31'b0, d_wr}, 32'd1);
    chk("st_d_addr", d_addr, 32'h100);
    chk("st_d_wdata", d_wdata, 32'hDEADBEEF);
    chk("st_d_wstrb", {28'b0, d_wstrb}, 32'hF);
    chk("st_d_size", {30'b0, d_size}, 32'd2);
    tick;
    chk("st_busy_inflight", {31'b0, busy}, 32'd1);
    chk("st_d_req_drained", {31'b0, d_req}, 32'd0);
    tick;
    respond(32'h0, 1);
    chk("st_busy_done", {31'b0, busy}, 32'd0);

    // fill to DEPTH, backpressure, then MAX_OUT stall
    u_wr = 0; u_wdata = 0; u_wstrb = 0; d_addr_ok = 0;
    for (int i = 0; i < 10; i++) begin
      u_req = vt[i].req; u_addr = vt[i].addr; d_addr_ok = vt[i].dok;
      #1;
      chk($sformatf("vec%0d_addr_ok", i), {31'b0, u_addr_ok}, {31'b0, vt[i].exp_ok});
      chk($sformatf("vec%0d_d_req", i), {31'b0, d_req}, {31'b0, vt[i].exp_dreq});
      if (vt[i].exp_dreq) chk($sformatf("vec%0d_d_addr", i), d_addr, vt[i].exp_daddr);
      tick;
    end
    u_req = 0;
    chk("maxout_busy", {31'b0, busy}, 32'd1);
    respond(32'h12345678, 1);
    chk("maxout_d_req_back", {31'b0, d_req}, 32'd1);
    chk("maxout_d_addr", d_addr, 32'h210);
    for (int i = 0; i < 4; i++) respond(32'h11110000 + i, 1);
    d_addr_ok = 0;
    chk("fill_busy_done", {31'b0, busy}, 32'd0);

    // flush: A in flight, store B and load C queued
    u_req = 1; u_wr = 0; u_addr = 32'h300; u_size = 2;
    tick;
    u_wr = 1; u_addr = 32'h304; u_size = 1; u_wdata = 32'hCAFEF00D; u_wstrb = 4'h3;
    d_addr_ok = 1;
    #1;
    chk("fl_issue_a", d_addr, 32'h300);
    tick;
    u_wr = 0; u_addr = 32'h308; u_size = 2; u_wdata = 0; u_wstrb = 0; d_addr_ok = 0;
    tick;
    u_addr = 32'h30C; flush = 1;
    #1;
    chk("fl_blocks_accept", {31'b0, u_addr_ok}, 32'd0);
    tick;
    u_req = 0; flush = 0;
    #1;
    chk("fl_b_d_req", {31'b0, d_req}, 32'd1);
    chk("fl_b_d_addr", d_addr, 32'h304);
    chk("fl_b_d_wdata", d_wdata, 32'hCAFEF00D);
    d_addr_ok = 1;
    tick;
    chk("fl_c_no_d_req", {31'b0, d_req}, 32'd0);
    chk("fl_c_busy", {31'b0, busy}, 32'd1);
    tick;
    d_addr_ok = 0;
    chk("fl_empty_busy", {31'b0, busy}, 32'd1);
    respond(32'hBAD0BAD0, 0);
    respond(32'h00000000, 1);
    chk("fl_busy_done", {31'b0, busy}, 32'd0);

    // flush in the same cycle a load is accepted downstream
    u_req = 1; u_addr = 32'h400;
    tick;
    u_req = 0; d_addr_ok = 1; flush = 1;
    #1;
    chk("fl_same_d_req", {31'b0, d_req}, 32'd1);
    tick;
    flush = 0; d_addr_ok = 0;
    respond(32'h00005555, 0);
    chk("fl_same_busy", {31'b0, busy}, 32'd0);

    // simultaneous issue and return
    u_req = 1; u_addr = 32'h500; d_addr_ok = 1;
    tick;
    u_addr = 32'h504;
    tick;
    u_req = 0; d_data_ok = 1; d_rdata = 32'hAAAA5555; sb.push_back(32'hAAAA5555);
    tick;
    d_data_ok = 0; d_rdata = 0; d_addr_ok = 0;
    #1;
    chk("sim_u_data_ok", {31'b0, u_data_ok}, 32'd1);
    chk("sim_out_cnt", 32'(dut.out_cnt), 32'd1);
    respond(32'h0F0F0F0F, 1);
    chk("sim_busy_done", {31'b0, busy}, 32'd0);

    // reset mid-transaction, then a stale response
    u_req = 1; u_addr = 32'h600; d_addr_ok = 1;
    tick;
    u_addr = 32'h604;
    tick;
    u_addr = 32'h608; d_addr_ok = 0;
    tick;
    u_req = 0; reset = 0;
    tick;
    chk("mid_rst_u_data_ok", {31'b0, u_data_ok}, 32'd0);
    chk("mid_rst_u_rdata", u_rdata, 32'd0);
    chk("mid_rst_d_req", {31'b0, d_req}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    reset = 1;
    tick;
    $display("[TB] note: injecting d_data_ok with no request outstanding (protocol error)");
    respond(32'h77777777, 0);
    chk("late_busy", {31'b0, busy}, 32'd0);
    tick;
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
